clock_mode_ctrl: RTL and testbench

//  Front-panel sequencer for the digital clock. Turns four debounced buttons into single-cycle strobes.

---
 rtl/clock_pkg.sv | 40 ++++
 rtl/clock_mode_ctrl_btn_pulse.sv | 65 ++++++
 rtl/clock_mode_ctrl.sv | 119 +++++++++++
 tb/tb_clock_mode_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared mode codes, client indices and mode-to-client helpers for the clock front panel.
package clock_pkg;

  localparam int NUM_CLIENTS = 3;
  localparam int CL_TIME     = 0;
  localparam int CL_ALARM    = 1;
  localparam int CL_TIMER    = 2;

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_TIME  = 2'd1,
    MODE_ALARM = 2'd2,
    MODE_TIMER = 2'd3
  } mode_t;

  // One-hot select of the setter owned by a mode; CLOCK owns none.
  function automatic logic [NUM_CLIENTS-1:0] client_mask(mode_t m);
    logic [NUM_CLIENTS-1:0] r;
    r = '0;
    case (m)
      MODE_TIME:  r[CL_TIME]  = 1'b1;
      MODE_ALARM: r[CL_ALARM] = 1'b1;
      MODE_TIMER: r[CL_TIMER] = 1'b1;
      default:    r = '0;
    endcase
    return r;
  endfunction

  function automatic mode_t next_mode(mode_t m);
    mode_t r;
    case (m)
      MODE_CLOCK: r = MODE_TIME;
      MODE_TIME:  r = MODE_ALARM;
      MODE_ALARM: r = MODE_TIMER;
      default:    r = MODE_CLOCK;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/clock_mode_ctrl_btn_pulse.sv
// Rising-edge detector for one debounced button, with an optional hold-to-repeat counter.
module btn_pulse #(
  parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY  = 1500000,
  parameter int REPEAT_PERIOD = 300000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  input  logic hold_en,
  input  logic clear,
  output logic req
);

  localparam bit REP_ACTIVE = REPEAT_EN && (REPEAT_DELAY >= 1) && (REPEAT_PERIOD >= 1);

  logic btn_q;
  logic rise;

  // Loads the live level even during reset, so a button held through reset never strobes.
  always_ff @(posedge clk) btn_q <= btn;

  assign rise = btn & ~btn_q;

  generate
    if (REP_ACTIVE) begin : g_rep
      localparam int MAXV = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(MAXV + 1);

      logic [RW-1:0] cnt;
      logic          first;
      logic          held;
      logic          hit;

      assign held = btn & btn_q & hold_en & ~clear;
      assign hit  = held && (cnt == (first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD)));

      // cnt counts held cycles since the edge strobe (or since the last repeat strobe)
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt   <= '0;
          first <= 1'b1;
        end else if (rise && hold_en && !clear) begin
          cnt   <= RW'(1);
          first <= 1'b1;
        end else if (!held) begin
          cnt   <= '0;
          first <= 1'b1;
        end else if (hit) begin
          cnt   <= RW'(1);
          first <= 1'b0;
        end else begin
          cnt   <= cnt + RW'(1);
        end
      end

      assign req = rise | hit;
    end else begin : g_edge
      logic unused_ok;
      assign unused_ok = &{1'b0, reset, hold_en, clear};
      assign req = rise;
    end
  endgenerate

endmodule

// File: rtl/clock_mode_ctrl.sv
// Front-panel sequencer: button strobes, mode FSM with edit lock, commit/abort generation.
// Define AUTO_REPEAT_EN to enable hold-to-repeat on the up/down buttons.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 6000000,
  parameter int REPEAT_DELAY   = 1500000,
  parameter int REPEAT_PERIOD  = 300000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_mode,
  input  logic                   btn_set,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic [NUM_CLIENTS-1:0] client_busy,
  input  logic [NUM_CLIENTS-1:0] client_propagate,
  output logic [1:0]             mode,
  output logic [NUM_CLIENTS-1:0] client_set,
  output logic [NUM_CLIENTS-1:0] client_up,
  output logic [NUM_CLIENTS-1:0] client_down,
  output logic [NUM_CLIENTS-1:0] client_abort,
  output logic [NUM_CLIENTS-1:0] commit
);

`ifdef AUTO_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  mode_t                  mode_q, mode_d;
  logic [NUM_CLIENTS-1:0] act_mask;
  logic                   act_valid, busy_act, prop_act;
  logic                   mode_req, set_req, up_req, down_req, mode_take;
  logic [TO_W-1:0]        to_cnt, to_cnt_d;
  logic [NUM_CLIENTS-1:0] set_d, up_d, down_d, abort_d, commit_d;

  assign act_mask  = client_mask(mode_q);
  assign act_valid = (mode_q != MODE_CLOCK);
  assign busy_act  = |(client_busy & act_mask);
  assign prop_act  = |(client_propagate & act_mask);
  assign mode_take = mode_req & ~busy_act;

  btn_pulse #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_mode (
    .clk(clk), .reset(reset), .btn(btn_mode), .hold_en(1'b0), .clear(1'b0), .req(mode_req));

  btn_pulse #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_set (
    .clk(clk), .reset(reset), .btn(btn_set), .hold_en(1'b0), .clear(1'b0), .req(set_req));

  // A higher-priority press that wins the cycle restarts the lower button's repeat timing.
  btn_pulse #(.REPEAT_EN(REP_EN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
    .clk(clk), .reset(reset), .btn(btn_up), .hold_en(act_valid),
    .clear(mode_take | set_req), .req(up_req));

  btn_pulse #(.REPEAT_EN(REP_EN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_down (
    .clk(clk), .reset(reset), .btn(btn_down), .hold_en(act_valid),
    .clear(mode_take | set_req | up_req), .req(down_req));

  // Precedence: propagate > unlocked mode press > routed strobe > timeout.
  always_comb begin
    mode_d   = mode_q;
    to_cnt_d = to_cnt;
    set_d    = '0;
    up_d     = '0;
    down_d   = '0;
    abort_d  = '0;
    commit_d = '0;
    if (prop_act) begin
      commit_d = act_mask;
      mode_d   = MODE_CLOCK;
      to_cnt_d = '0;
    end else if (mode_take) begin
      mode_d   = next_mode(mode_q);
      to_cnt_d = '0;
    end else if (act_valid && (set_req || up_req || down_req)) begin
      if (set_req)     set_d  = act_mask;
      else if (up_req) up_d   = act_mask;
      else             down_d = act_mask;
      to_cnt_d = '0;
    end else if (!busy_act) begin
      to_cnt_d = '0;
    end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
      abort_d  = act_mask;
      mode_d   = MODE_CLOCK;
      to_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) mode_q <= MODE_CLOCK;
    else       mode_q <= mode_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt       <= '0;
      client_set   <= '0;
      client_up    <= '0;
      client_down  <= '0;
      client_abort <= '0;
      commit       <= '0;
    end else begin
      to_cnt       <= to_cnt_d;
      client_set   <= set_d;
      client_up    <= up_d;
      client_down  <= down_d;
      client_abort <= abort_d;
      commit       <= commit_d;
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: cycle model compared every cycle plus literal checkpoints.
module tb_clock_mode_ctrl;

  localparam int TO = 16;
  localparam int RD = 8;
  localparam int RP = 4;
`ifdef AUTO_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_mode = 1'b0, btn_set = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic [2:0] client_busy = 3'b000, client_propagate = 3'b000;
  logic [1:0] mode;
  logic [2:0] client_set, client_up, client_down, client_abort, commit;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  clock_mode_ctrl #(.TIMEOUT_CYCLES(TO), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_set(btn_set), .btn_up(btn_up), .btn_down(btn_down),
    .client_busy(client_busy), .client_propagate(client_propagate),
    .mode(mode), .client_set(client_set), .client_up(client_up), .client_down(client_down),
    .client_abort(client_abort), .commit(commit));

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode as an integer 0..3, timeout as an idle count, repeat as held-cycle count k.
  int         m_mode, m_to, k_up, k_dn;
  bit         p_mode, p_set, p_up, p_dn;
  bit         model_valid = 1'b0;
  logic [1:0] e_mode;
  logic [2:0] e_set, e_up, e_dn, e_abort, e_commit;

  function automatic bit rep_fire(input int k);
    return (k == RD) || (k > RD && ((k - RD) % RP) == 0);
  endfunction

  always @(posedge clk) begin : model
    bit r_mode, r_set, r_up, r_dn, busy, prop, take, en, f_up, f_dn, up_req, dn_req;
    logic [2:0] mask;
    if (reset) begin
      m_mode = 0; m_to = 0; k_up = -1; k_dn = -1;
      e_mode = 2'd0; e_set = 3'b0; e_up = 3'b0; e_dn = 3'b0; e_abort = 3'b0; e_commit = 3'b0;
    end else begin
      mask   = (m_mode == 0) ? 3'b000 : 3'(1 << (m_mode - 1));
      busy   = |(client_busy & mask);
      prop   = |(client_propagate & mask);
      r_mode = btn_mode && !p_mode;
      r_set  = btn_set && !p_set;
      r_up   = btn_up && !p_up;
      r_dn   = btn_down && !p_dn;
      en     = (m_mode != 0);
      take   = r_mode && !busy;
      f_up = 1'b0;
      if (!REP || !btn_up || !en || take || r_set) k_up = -1;
      else if (r_up) k_up = 0;
      else begin k_up++; f_up = rep_fire(k_up); end
      up_req = r_up || f_up;
      f_dn = 1'b0;
      if (!REP || !btn_down || !en || take || r_set || up_req) k_dn = -1;
      else if (r_dn) k_dn = 0;
      else begin k_dn++; f_dn = rep_fire(k_dn); end
      dn_req = r_dn || f_dn;
      e_set = 3'b0; e_up = 3'b0; e_dn = 3'b0; e_abort = 3'b0; e_commit = 3'b0;
      if (prop) begin
        e_commit = mask; m_mode = 0; m_to = 0;
      end else if (take) begin
        m_mode = (m_mode + 1) % 4; m_to = 0;
      end else if (en && (r_set || up_req || dn_req)) begin
        if (r_set) e_set = mask;
        else if (up_req) e_up = mask;
        else e_dn = mask;
        m_to = 0;
      end else if (!busy) begin
        m_to = 0;
      end else if (m_to == TO - 1) begin
        e_abort = mask; m_mode = 0; m_to = 0;
      end else begin
        m_to++;
      end
      e_mode = 2'(m_mode);
    end
    p_mode = btn_mode; p_set = btn_set; p_up = btn_up; p_dn = btn_down;
    model_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("mdl_mode",   {2'b0, mode},         {2'b0, e_mode});
      chk("mdl_set",    {1'b0, client_set},   {1'b0, e_set});
      chk("mdl_up",     {1'b0, client_up},    {1'b0, e_up});
      chk("mdl_down",   {1'b0, client_down},  {1'b0, e_dn});
      chk("mdl_abort",  {1'b0, client_abort}, {1'b0, e_abort});
      chk("mdl_commit", {1'b0, commit},       {1'b0, e_commit});
    end
  end

  task automatic set_btn(input int b, input logic v);
    case (b)
      0: btn_mode = v;
      1: btn_set  = v;
      2: btn_up   = v;
      default: btn_down = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    @(negedge clk);
    set_btn(b, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_mode",   {2'b0, mode},         4'd0);
    chk("rst_set",    {1'b0, client_set},   4'd0);
    chk("rst_abort",  {1'b0, client_abort}, 4'd0);
    chk("rst_commit", {1'b0, commit},       4'd0);
    reset = 1'b0;
    idle(2);

    // Mode cycling with nothing busy
    for (int i = 1; i <= 4; i++) begin
      press(0);
      chk("cycle_mode", {2'b0, mode}, 4'(i % 4));
      idle(1);
    end

    // TIME edits: set, two ups, then locked mode press
    press(0); idle(1);
    press(1);
    chk("set_strobe", {1'b0, client_set}, 4'b0001);
    idle(1);
    chk("set_1cyc", {1'b0, client_set}, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      press(2);
      chk("up_strobe", {1'b0, client_up}, 4'b0001);
      idle(1);
      chk("up_1cyc", {1'b0, client_up}, 4'b0000);
    end
    client_busy = 3'b001;
    press(0);
    chk("mode_locked", {2'b0, mode}, 4'd1);
    idle(1);

    // Propagate commits and returns to CLOCK
    client_propagate = 3'b001;
    @(negedge clk);
    client_propagate = 3'b000;
    client_busy = 3'b000;
    chk("prop_commit", {1'b0, commit},       4'b0001);
    chk("prop_mode",   {2'b0, mode},         4'd0);
    chk("prop_abort",  {1'b0, client_abort}, 4'd0);
    idle(1);
    chk("commit_1cyc", {1'b0, commit}, 4'd0);

    // ALARM edit abandoned until timeout
    press(0); idle(1);
    press(0); idle(1);
    chk("alarm_mode", {2'b0, mode}, 4'd2);
    client_busy = 3'b010;
    idle(15);
    chk("to_early", {1'b0, client_abort}, 4'd0);
    idle(1);
    chk("to_abort",  {1'b0, client_abort}, 4'b0010);
    chk("to_mode",   {2'b0, mode},         4'd0);
    chk("to_commit", {1'b0, commit},       4'd0);
    client_busy = 3'b000;
    idle(1);
    chk("abort_1cyc", {1'b0, client_abort}, 4'd0);

    // TIMER: simultaneous presses resolve by priority
    for (int i = 0; i < 3; i++) begin press(0); idle(1); end
    chk("timer_mode", {2'b0, mode}, 4'd3);
    btn_set = 1'b1; btn_up = 1'b1; btn_down = 1'b1;
    @(negedge clk);
    chk("prio_set",  {1'b0, client_set},  4'b0100);
    chk("prio_up",   {1'b0, client_up},   4'b0000);
    chk("prio_down", {1'b0, client_down}, 4'b0000);
    btn_set = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    idle(1);
    btn_mode = 1'b1; btn_set = 1'b1;
    @(negedge clk);
    chk("ms_mode", {2'b0, mode},       4'd0);
    chk("ms_set",  {1'b0, client_set}, 4'd0);
    btn_mode = 1'b0; btn_set = 1'b0;
    idle(1);

    // Hold up for 20 cycles in TIME
    press(0); idle(1);
    btn_up = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      chk("hold_up", {1'b0, client_up},
          ((i == 1) || (REP && (i == 9 || i == 13 || i == 17))) ? 4'b0001 : 4'b0000);
    end
    btn_up = 1'b0;
    idle(2);

    // Button held through reset gives no strobe
    btn_mode = 1'b1;
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(2);
    chk("held_thru_reset", {2'b0, mode}, 4'd0);
    btn_mode = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
